// File: rtl/blit_line_copier_if.sv
// AXI4 channel bundle between the blitter copy engine (master) and the SDRAM controller (slave).
// Only the fields the copy engine drives or consumes are carried.
interface intf_axi4 #(
    parameter int DATA_WIDTH = 16
) ();
    logic                  m_arvalid;
    logic                  s_arready;
    logic [31:0]           m_araddr;
    logic [7:0]            m_arlen;
    logic [2:0]            m_arsize;
    logic [1:0]            m_arburst;

    logic                  s_rvalid;
    logic                  m_rready;
    logic [DATA_WIDTH-1:0] s_rdata;

    logic                  m_awvalid;
    logic                  s_awready;
    logic [31:0]           m_awaddr;
    logic [7:0]            m_awlen;
    logic [2:0]            m_awsize;
    logic [1:0]            m_awburst;

    logic                  m_wvalid;
    logic                  s_wready;
    logic [DATA_WIDTH-1:0] m_wdata;
    logic                  m_wlast;

    logic                  m_bready;

    modport master (
        output m_arvalid, m_araddr, m_arlen, m_arsize, m_arburst, m_rready,
        output m_awvalid, m_awaddr, m_awlen, m_awsize, m_awburst,
        output m_wvalid, m_wdata, m_wlast, m_bready,
        input  s_arready, s_rvalid, s_rdata, s_awready, s_wready
    );

    modport slave (
        input  m_arvalid, m_araddr, m_arlen, m_arsize, m_arburst, m_rready,
        input  m_awvalid, m_awaddr, m_awlen, m_awsize, m_awburst,
        input  m_wvalid, m_wdata, m_wlast, m_bready,
        output s_arready, s_rvalid, s_rdata, s_awready, s_wready
    );
endinterface

// File: rtl/blit_line_copier.sv
// Blitter rectangle copy engine: reads source lines in bursts into a FIFO and writes them to the
// destination, with independent read and write FSMs each keeping at most one burst outstanding.
module blit_line_copier #(
    parameter int DATA_WIDTH = 16,
    parameter int MAX_BURST  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [31:0] i_src_addr,
    input  logic [31:0] i_dst_addr,
    input  logic [15:0] i_width,
    input  logic [11:0] i_height,
    input  logic [31:0] i_src_stride,
    input  logic [31:0] i_dst_stride,
    output logic        o_busy,
    output logic        o_done,
    intf_axi4.master    axi_bus
);
    localparam int BPW    = DATA_WIDTH / 8;
    localparam int SIZE   = $clog2(BPW);
    localparam int BLEN_W = $clog2(MAX_BURST + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef enum logic [1:0] {TOP_IDLE, TOP_RUN, TOP_DONE} top_state_t;
    typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_DATA} rd_state_t;
    typedef enum logic [1:0] {WR_IDLE, WR_ADDR, WR_DATA} wr_state_t;

    top_state_t r_top, w_top_next;
    rd_state_t  r_rd,  w_rd_next;
    wr_state_t  r_wr,  w_wr_next;

    logic [15:0]           r_width;
    logic [31:0]           r_src_stride, r_dst_stride;
    logic [11:0]           r_rd_lines, r_wr_lines;
    logic [15:0]           r_rd_words, r_wr_words;
    logic [31:0]           r_rd_ptr, r_rd_base, r_wr_ptr, r_wr_base;
    logic [BLEN_W-1:0]     r_rd_inflight, r_wr_beats;
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_fifo_wp, r_fifo_rp;
    logic [CNT_W-1:0]      r_fifo_count;

    logic                  w_accept, w_zero, w_ar_hs, w_aw_hs, w_push, w_pop;
    logic                  w_rd_space_ok, w_wr_data_ok, w_final_beat;
    logic [BLEN_W-1:0]     w_rd_blen, w_wr_blen;

    assign w_accept  = (r_top == TOP_IDLE) && i_start;
    assign w_zero    = (i_width == 16'd0) || (i_height == 12'd0);
    assign w_rd_blen = (r_rd_words >= 16'(MAX_BURST)) ? BLEN_W'(MAX_BURST) : r_rd_words[BLEN_W-1:0];
    assign w_wr_blen = (r_wr_words >= 16'(MAX_BURST)) ? BLEN_W'(MAX_BURST) : r_wr_words[BLEN_W-1:0];

    // Space is reserved for the whole burst before AR is issued, so R beats can always be accepted.
    assign w_rd_space_ok = (32'(r_fifo_count) + 32'(r_rd_inflight) + 32'(w_rd_blen)) <= 32'(FIFO_DEPTH);
    assign w_wr_data_ok  = 32'(r_fifo_count) >= 32'(w_wr_blen);

    assign w_ar_hs      = (r_rd == RD_ADDR) && axi_bus.s_arready;
    assign w_aw_hs      = (r_wr == WR_ADDR) && axi_bus.s_awready;
    assign w_push       = (r_rd == RD_DATA) && axi_bus.s_rvalid && axi_bus.m_rready;
    assign w_pop        = (r_wr == WR_DATA) && axi_bus.s_wready;
    assign w_final_beat = w_pop && (r_wr_beats == BLEN_W'(1)) && (r_wr_lines == 12'd0);

    assign axi_bus.m_arvalid = (r_rd == RD_ADDR);
    assign axi_bus.m_araddr  = r_rd_ptr;
    assign axi_bus.m_arlen   = 8'(w_rd_blen) - 8'd1;
    assign axi_bus.m_arsize  = 3'(SIZE);
    assign axi_bus.m_arburst = 2'b01;
    assign axi_bus.m_rready  = 1'b1;
    assign axi_bus.m_awvalid = (r_wr == WR_ADDR);
    assign axi_bus.m_awaddr  = r_wr_ptr;
    assign axi_bus.m_awlen   = 8'(w_wr_blen) - 8'd1;
    assign axi_bus.m_awsize  = 3'(SIZE);
    assign axi_bus.m_awburst = 2'b01;
    assign axi_bus.m_wvalid  = (r_wr == WR_DATA);
    assign axi_bus.m_wdata   = r_mem[r_fifo_rp];
    assign axi_bus.m_wlast   = (r_wr == WR_DATA) && (r_wr_beats == BLEN_W'(1));
    assign axi_bus.m_bready  = 1'b1;

    assign o_busy = (r_top == TOP_RUN);
    assign o_done = (r_top == TOP_DONE);

    always_comb begin
        w_top_next = r_top;
        w_rd_next  = r_rd;
        w_wr_next  = r_wr;
        case (r_top)
            TOP_IDLE: if (i_start) w_top_next = w_zero ? TOP_DONE : TOP_RUN;
            TOP_RUN:  if (w_final_beat) w_top_next = TOP_DONE;
            default:  w_top_next = TOP_IDLE;
        endcase
        case (r_rd)
            RD_IDLE: if (r_top == TOP_RUN && r_rd_lines != 12'd0 && w_rd_space_ok) w_rd_next = RD_ADDR;
            RD_ADDR: if (axi_bus.s_arready) w_rd_next = RD_DATA;
            RD_DATA: if (w_push && r_rd_inflight == BLEN_W'(1)) w_rd_next = RD_IDLE;
            default: w_rd_next = RD_IDLE;
        endcase
        case (r_wr)
            WR_IDLE: if (r_top == TOP_RUN && r_wr_lines != 12'd0 && w_wr_data_ok) w_wr_next = WR_ADDR;
            WR_ADDR: if (axi_bus.s_awready) w_wr_next = WR_DATA;
            WR_DATA: if (w_pop && r_wr_beats == BLEN_W'(1)) w_wr_next = WR_IDLE;
            default: w_wr_next = WR_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_top         <= TOP_IDLE;
            r_rd          <= RD_IDLE;
            r_wr          <= WR_IDLE;
            r_width       <= '0;
            r_src_stride  <= '0;
            r_dst_stride  <= '0;
            r_rd_lines    <= '0;
            r_wr_lines    <= '0;
            r_rd_words    <= '0;
            r_wr_words    <= '0;
            r_rd_ptr      <= '0;
            r_rd_base     <= '0;
            r_wr_ptr      <= '0;
            r_wr_base     <= '0;
            r_rd_inflight <= '0;
            r_wr_beats    <= '0;
            r_fifo_wp     <= '0;
            r_fifo_rp     <= '0;
            r_fifo_count  <= '0;
        end else begin
            r_top <= w_top_next;
            r_rd  <= w_rd_next;
            r_wr  <= w_wr_next;
            if (w_accept) begin
                r_width      <= i_width;
                r_src_stride <= i_src_stride;
                r_dst_stride <= i_dst_stride;
                r_rd_lines   <= w_zero ? 12'd0 : i_height;
                r_wr_lines   <= w_zero ? 12'd0 : i_height;
                r_rd_words   <= i_width;
                r_wr_words   <= i_width;
                r_rd_ptr     <= i_src_addr;
                r_rd_base    <= i_src_addr;
                r_wr_ptr     <= i_dst_addr;
                r_wr_base    <= i_dst_addr;
            end
            // Pointers advance at the address handshake; the line ends exactly on a burst boundary.
            if (w_ar_hs) begin
                r_rd_inflight <= w_rd_blen;
                if (r_rd_words == 16'(w_rd_blen)) begin
                    r_rd_lines <= r_rd_lines - 12'd1;
                    r_rd_words <= r_width;
                    r_rd_base  <= r_rd_base + r_src_stride;
                    r_rd_ptr   <= r_rd_base + r_src_stride;
                end else begin
                    r_rd_words <= r_rd_words - 16'(w_rd_blen);
                    r_rd_ptr   <= r_rd_ptr + (32'(w_rd_blen) << SIZE);
                end
            end else if (w_push) begin
                r_rd_inflight <= r_rd_inflight - BLEN_W'(1);
            end
            if (w_aw_hs) begin
                r_wr_beats <= w_wr_blen;
                if (r_wr_words == 16'(w_wr_blen)) begin
                    r_wr_lines <= r_wr_lines - 12'd1;
                    r_wr_words <= r_width;
                    r_wr_base  <= r_wr_base + r_dst_stride;
                    r_wr_ptr   <= r_wr_base + r_dst_stride;
                end else begin
                    r_wr_words <= r_wr_words - 16'(w_wr_blen);
                    r_wr_ptr   <= r_wr_ptr + (32'(w_wr_blen) << SIZE);
                end
            end else if (w_pop) begin
                r_wr_beats <= r_wr_beats - BLEN_W'(1);
            end
            if (w_push) r_fifo_wp <= r_fifo_wp + PTR_W'(1);
            if (w_pop)  r_fifo_rp <= r_fifo_rp + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_fifo_count <= r_fifo_count + CNT_W'(1);
                2'b01:   r_fifo_count <= r_fifo_count - CNT_W'(1);
                default: r_fifo_count <= r_fifo_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_fifo_wp] <= axi_bus.s_rdata;
    end

    a_fifo_no_overflow: assert property (@(posedge i_clk) disable iff (i_reset)
        !(w_push && !w_pop && r_fifo_count == CNT_W'(FIFO_DEPTH)));
endmodule

// File: tb/tb_blit_line_copier.sv
// Self-checking bench for blit_line_copier: an AXI slave returns address-derived source words and a
// transaction-level model predicts every AR/AW/W beat and the done pulse.
module tb_blit_line_copier;
    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_start = 1'b0;
    logic [31:0] i_src_addr = '0, i_dst_addr = '0, i_src_stride = '0, i_dst_stride = '0;
    logic [15:0] i_width = '0;
    logic [11:0] i_height = '0;
    logic        o_busy, o_done;

    intf_axi4 #(.DATA_WIDTH(16)) axi ();

    blit_line_copier #(.DATA_WIDTH(16), .MAX_BURST(8), .FIFO_DEPTH(16)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start),
        .i_src_addr(i_src_addr), .i_dst_addr(i_dst_addr),
        .i_width(i_width), .i_height(i_height),
        .i_src_stride(i_src_stride), .i_dst_stride(i_dst_stride),
        .o_busy(o_busy), .o_done(o_done), .axi_bus(axi)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_ar_addr[$], exp_aw_addr[$], ar_log_addr[$], aw_log_addr[$];
    int          exp_ar_len[$], exp_aw_len[$], ar_log_len[$], aw_log_len[$];
    logic [15:0] exp_w_data[$];
    bit          exp_w_last[$];
    int          done_cnt = 0, rbeats = 0, wbeats = 0;
    bit          exp_done_next = 0, zero_flag = 0, wready_hold = 0;

    bit          rd_active = 0;
    logic [31:0] rd_addr = '0;
    int          rd_left = 0;
    int          cyc = 0;

    function automatic logic [15:0] src_word(input logic [31:0] a);
        return a[16:1] ^ a[31:16] ^ 16'hC3A5;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic build_model(input int w, input int h, input logic [31:0] src, input logic [31:0] dst,
                               input logic [31:0] ss, input logic [31:0] ds);
        exp_ar_addr.delete(); exp_ar_len.delete(); exp_aw_addr.delete(); exp_aw_len.delete();
        exp_w_data.delete(); exp_w_last.delete();
        for (int ln = 0; ln < h; ln++) begin
            for (int off = 0; off < w; off += 8) begin
                int n;
                n = (w - off < 8) ? (w - off) : 8;
                exp_ar_addr.push_back(src + 32'(ln) * ss + 32'(off * 2));
                exp_aw_addr.push_back(dst + 32'(ln) * ds + 32'(off * 2));
                exp_ar_len.push_back(n - 1);
                exp_aw_len.push_back(n - 1);
                for (int k = 0; k < n; k++) begin
                    exp_w_data.push_back(src_word(src + 32'(ln) * ss + 32'((off + k) * 2)));
                    exp_w_last.push_back(k == n - 1);
                end
            end
        end
    endtask

    // Slave responder and per-cycle monitor: sample at negedge, update slave drive after posedge.
    initial begin
        bit hs_ar, hs_r, hs_aw, hs_w, final_w;
        logic [31:0] ar_a;
        int ar_l;
        axi.s_arready = 1'b1; axi.s_rvalid = 1'b0; axi.s_rdata = '0;
        axi.s_awready = 1'b1; axi.s_wready = 1'b1;
        forever begin
            @(negedge i_clk);
            hs_ar = 0; hs_r = 0; hs_aw = 0; hs_w = 0; final_w = 0;
            if (i_reset) begin
                exp_done_next = 0;
            end else begin
                hs_ar = axi.m_arvalid && axi.s_arready;
                hs_r  = axi.s_rvalid && axi.m_rready;
                hs_aw = axi.m_awvalid && axi.s_awready;
                hs_w  = axi.m_wvalid && axi.s_wready;
                if (hs_ar) begin
                    ar_a = axi.m_araddr;
                    ar_l = int'(axi.m_arlen);
                    ar_log_addr.push_back(ar_a);
                    ar_log_len.push_back(ar_l);
                    chk("ar_space", 32'((rbeats - wbeats + ar_l + 1) <= 16), 32'd1);
                    chk("ar_size", 32'(axi.m_arsize), 32'd1);
                    chk("ar_burst", 32'(axi.m_arburst), 32'd1);
                    chk("ar_expected", 32'(exp_ar_addr.size() != 0), 32'd1);
                    if (exp_ar_addr.size() != 0) begin
                        chk("ar_addr", ar_a, exp_ar_addr.pop_front());
                        chk("ar_len", 32'(ar_l), 32'(exp_ar_len.pop_front()));
                    end
                end
                if (hs_aw) begin
                    aw_log_addr.push_back(axi.m_awaddr);
                    aw_log_len.push_back(int'(axi.m_awlen));
                    chk("aw_size", 32'(axi.m_awsize), 32'd1);
                    chk("aw_expected", 32'(exp_aw_addr.size() != 0), 32'd1);
                    if (exp_aw_addr.size() != 0) begin
                        chk("aw_addr", axi.m_awaddr, exp_aw_addr.pop_front());
                        chk("aw_len", 32'(axi.m_awlen), 32'(exp_aw_len.pop_front()));
                    end
                end
                if (hs_w) begin
                    chk("w_expected", 32'(exp_w_data.size() != 0), 32'd1);
                    if (exp_w_data.size() != 0) begin
                        chk("w_data", 32'(axi.m_wdata), 32'(exp_w_data.pop_front()));
                        chk("w_last", 32'(axi.m_wlast), 32'(exp_w_last.pop_front()));
                        final_w = (exp_w_data.size() == 0);
                    end
                    wbeats++;
                end
                if (hs_r) rbeats++;
                chk("done", 32'(o_done), 32'(exp_done_next));
                if (o_done) done_cnt++;
                exp_done_next = final_w || (i_start && zero_flag && !o_busy && !o_done);
            end
            @(posedge i_clk);
            #1;
            cyc++;
            if (i_reset) begin
                rd_active = 0;
            end else begin
                if (hs_r) begin
                    rd_addr = rd_addr + 32'd2;
                    rd_left--;
                    if (rd_left == 0) rd_active = 0;
                end
                if (hs_ar) begin
                    rd_active = 1;
                    rd_addr   = ar_a;
                    rd_left   = ar_l + 1;
                end
            end
            axi.s_rvalid  = rd_active && (cyc % 5 != 3);
            axi.s_rdata   = src_word(rd_addr);
            axi.s_arready = !rd_active;
            axi.s_awready = (cyc % 3 != 1);
            axi.s_wready  = !wready_hold && (cyc % 7 != 2);
        end
    end

    task automatic run_copy(input int w, input int h, input logic [31:0] src, input logic [31:0] dst,
                            input logic [31:0] ss, input logic [31:0] ds, input int hold);
        int t;
        build_model(w, h, src, dst, ss, ds);
        ar_log_addr.delete(); ar_log_len.delete(); aw_log_addr.delete(); aw_log_len.delete();
        done_cnt = 0; rbeats = 0; wbeats = 0;
        @(posedge i_clk); #1;
        i_width = 16'(w); i_height = 12'(h); i_src_addr = src; i_dst_addr = dst;
        i_src_stride = ss; i_dst_stride = ds;
        zero_flag = (w == 0) || (h == 0);
        wready_hold = (hold > 0);
        i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        @(negedge i_clk);
        chk("busy_after_start", 32'(o_busy), 32'(!zero_flag));
        if (hold > 0) begin
            repeat (hold) @(negedge i_clk);
            chk("hold_fifo_level", 32'(rbeats - wbeats), 32'd16);
            chk("hold_no_w", 32'(wbeats), 32'd0);
            chk("hold_no_ar", 32'(axi.m_arvalid), 32'd0);
            @(posedge i_clk); #1;
            wready_hold = 0;
        end
        t = 0;
        while (done_cnt == 0 && t < 4000) begin
            @(negedge i_clk);
            t++;
        end
        chk("done_seen", 32'(done_cnt != 0), 32'd1);
        repeat (3) @(negedge i_clk);
        chk("done_count", 32'(done_cnt), 32'd1);
        chk("w_left", 32'(exp_w_data.size()), 32'd0);
        chk("ar_left", 32'(exp_ar_addr.size()), 32'd0);
        chk("aw_left", 32'(exp_aw_addr.size()), 32'd0);
        chk("busy_idle", 32'(o_busy), 32'd0);
        zero_flag = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_arvalid"}, 32'(axi.m_arvalid), 32'd0);
        chk({tag, "_awvalid"}, 32'(axi.m_awvalid), 32'd0);
        chk({tag, "_wvalid"}, 32'(axi.m_wvalid), 32'd0);
        chk({tag, "_busy"}, 32'(o_busy), 32'd0);
        chk({tag, "_done"}, 32'(o_done), 32'd0);
        chk({tag, "_rready"}, 32'(axi.m_rready), 32'd1);
        chk({tag, "_bready"}, 32'(axi.m_bready), 32'd1);
    endtask

    initial begin
        logic [31:0] e2_ar[3];
        logic [31:0] e2_aw[3];
        logic [31:0] e3_ar[3];
        logic [31:0] e3_aw[3];
        int          e2_len[3];
        int          t;
        e2_ar = '{32'h0, 32'h10, 32'h20};
        e2_aw = '{32'h1000, 32'h1010, 32'h1020};
        e2_len = '{7, 7, 3};
        e3_ar = '{32'h0, 32'h40, 32'h80};
        e3_aw = '{32'h2000, 32'h2080, 32'h2100};

        repeat (3) @(negedge i_clk);
        check_reset_outputs("reset");
        @(posedge i_clk); #1;
        i_reset = 1'b0;

        run_copy(4, 1, 32'h100, 32'h200, 32'h0, 32'h0, 0);
        chk("t1_ar_count", 32'(ar_log_addr.size()), 32'd1);
        chk("t1_ar_addr", ar_log_addr[0], 32'h100);
        chk("t1_ar_len", 32'(ar_log_len[0]), 32'd3);
        chk("t1_aw_addr", aw_log_addr[0], 32'h200);
        chk("t1_aw_len", 32'(aw_log_len[0]), 32'd3);
        chk("t1_wbeats", 32'(wbeats), 32'd4);

        run_copy(20, 1, 32'h0, 32'h1000, 32'h0, 32'h0, 0);
        chk("t2_ar_count", 32'(ar_log_addr.size()), 32'd3);
        chk("t2_aw_count", 32'(aw_log_addr.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk("t2_ar_addr", ar_log_addr[i], e2_ar[i]);
            chk("t2_ar_len", 32'(ar_log_len[i]), 32'(e2_len[i]));
            chk("t2_aw_addr", aw_log_addr[i], e2_aw[i]);
            chk("t2_aw_len", 32'(aw_log_len[i]), 32'(e2_len[i]));
        end

        run_copy(3, 3, 32'h0, 32'h2000, 32'h40, 32'h80, 0);
        chk("t3_ar_count", 32'(ar_log_addr.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk("t3_ar_addr", ar_log_addr[i], e3_ar[i]);
            chk("t3_aw_addr", aw_log_addr[i], e3_aw[i]);
        end

        run_copy(0, 5, 32'h100, 32'h200, 32'h10, 32'h10, 0);
        chk("t4a_no_ar", 32'(ar_log_addr.size()), 32'd0);
        chk("t4a_no_aw", 32'(aw_log_addr.size()), 32'd0);
        run_copy(7, 0, 32'h100, 32'h200, 32'h10, 32'h10, 0);
        chk("t4b_no_ar", 32'(ar_log_addr.size()), 32'd0);
        chk("t4b_no_aw", 32'(aw_log_addr.size()), 32'd0);

        run_copy(64, 1, 32'h4000, 32'h8000, 32'h0, 32'h0, 50);
        chk("t5_wbeats", 32'(wbeats), 32'd64);

        run_copy(4, 2, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h8, 32'h8, 0);
        chk("wrap_ar_line2", ar_log_addr[1], 32'h0);
        chk("wrap_aw_line2", aw_log_addr[1], 32'h4);

        build_model(16, 1, 32'h300, 32'h600, 32'h0, 32'h0);
        done_cnt = 0; rbeats = 0; wbeats = 0;
        @(posedge i_clk); #1;
        i_width = 16'd16; i_height = 12'd1; i_src_addr = 32'h300; i_dst_addr = 32'h600;
        i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        t = 0;
        while (rbeats < 3 && t < 200) begin
            @(negedge i_clk);
            t++;
        end
        chk("t6_mid_burst", 32'(rbeats >= 3), 32'd1);
        @(posedge i_clk); #1;
        i_reset = 1'b1;
        @(negedge i_clk);
        check_reset_outputs("t6_reset");
        repeat (2) @(posedge i_clk);
        #1;
        build_model(0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
        i_reset = 1'b0;
        repeat (5) @(negedge i_clk);
        chk("t6_no_done_after_reset", 32'(done_cnt), 32'd0);
        run_copy(2, 1, 32'h500, 32'h700, 32'h0, 32'h0, 0);
        chk("t6_wbeats", 32'(wbeats), 32'd2);
        chk("t6_ar_len", 32'(ar_log_len[0]), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
